// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// requester-index width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    always_comb begin
        // NOTE: defaults before the search loop keep every path assigned, so no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                winner = ID_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a start-handshake timeout and a freeze while the UART self-test runs.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 16,
    localparam int ID_W         = id_width(NUM_REQ)
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
    output logic [NUM_REQ-1:0]             Req_Ack,
    output logic [NUM_REQ-1:0]             Req_Done,
    output logic                           Req_Err,
    output logic [ID_W-1:0]                Grant_Id,
    output logic [DATA_BITS-1:0]           Tx_Data,
    output logic                           Transmit_Start,
    input  logic                           Tx_Busy,
    input  logic                           BIST_Busy,
    output logic                           Arb_Busy
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t             r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_grant_id;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic [NUM_REQ-1:0]     r_ack;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_err;
    logic                   r_start;

    logic [ID_W-1:0]        w_winner;
    logic                   w_valid;
    logic [ID_W-1:0]        w_next_ptr;
    logic [DATA_BITS-1:0]   w_win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (Req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    // Pointer moves just past the finished grant so the next search starts there.
    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
    assign w_win_data = Req_Data[int'(w_winner)*DATA_BITS +: DATA_BITS];

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
        if (Rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid && !Tx_Busy && !BIST_Busy) begin
                        r_tx_data         <= w_win_data;
                        r_grant_id        <= w_winner;
                        r_ack[w_winner]   <= 1'b1;
                        r_start           <= 1'b1;
                        r_cnt             <= '0;
                        r_state           <= START;
                    end
                end
                START: begin
                    if (Tx_Busy) begin
                        r_start <= 1'b0;
                        r_state <= SEND;
                    end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        // UART never acknowledged: release the grant and flag the abort.
                        r_start            <= 1'b0;
                        r_done[r_grant_id] <= 1'b1;
                        r_err              <= 1'b1;
                        r_ptr              <= w_next_ptr;
                        r_state            <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (!Tx_Busy) begin
                        r_done[r_grant_id] <= 1'b1;
                        r_ptr              <= w_next_ptr;
                        r_state            <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Req_Ack        = r_ack;
    assign Req_Done       = r_done;
    assign Req_Err        = r_err;
    assign Grant_Id       = r_grant_id;
    assign Tx_Data        = r_tx_data;
    assign Transmit_Start = r_start;
    assign Arb_Busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants,
// a small UART busy model, and directed fairness/timeout/BIST/reset scenarios.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int DATA_BITS     = 8;
    localparam int START_TIMEOUT = 16;
    localparam int ID_W          = id_width(NUM_REQ);

    logic                         Clk = 1'b0;
    logic                         Rst;
    logic [NUM_REQ-1:0]           Req;
    logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
    logic [NUM_REQ-1:0]           Req_Ack;
    logic [NUM_REQ-1:0]           Req_Done;
    logic                         Req_Err;
    logic [ID_W-1:0]              Grant_Id;
    logic [DATA_BITS-1:0]         Tx_Data;
    logic                         Transmit_Start;
    logic                         Tx_Busy;
    logic                         BIST_Busy;
    logic                         Arb_Busy;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_BITS     (DATA_BITS),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Req            (Req),
        .Req_Data       (Req_Data),
        .Req_Ack        (Req_Ack),
        .Req_Done       (Req_Done),
        .Req_Err        (Req_Err),
        .Grant_Id       (Grant_Id),
        .Tx_Data        (Tx_Data),
        .Transmit_Start (Transmit_Start),
        .Tx_Busy        (Tx_Busy),
        .BIST_Busy      (BIST_Busy),
        .Arb_Busy       (Arb_Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    int   check_cnt = 0;
    int   error_cnt = 0;
    int   uart_mode = 0;   // 0: UART answers Transmit_Start, 1: UART never goes busy

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        while (Req_Ack == '0 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_ack_seen"}, 32'(Req_Ack != '0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        while (Req_Done == '0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(Req_Done != '0), 32'd1);
    endtask

    // UART model: busy rises two cycles after a start strobe and lasts four cycles.
    initial begin
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (uart_mode == 0 && Transmit_Start && !Tx_Busy) begin
                repeat (2) @(negedge Clk);
                Tx_Busy = 1'b1;
                repeat (4) @(negedge Clk);
                Tx_Busy = 1'b0;
            end
        end
    end

    // Scoreboard: pop an expectation on every Ack, retire it on the matching Done.
    always @(negedge Clk) begin
        if (Req_Ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(Req_Ack), 32'd0);
            end else begin
                cur       = exp_q.pop_front();
                cur_valid = 1'b1;
                check("ack_onehot", 32'(Req_Ack), 32'(1 << cur.id));
                check("ack_grant_id", 32'(Grant_Id), 32'(cur.id));
                check("ack_tx_data", 32'(Tx_Data), 32'(cur.data));
            end
        end
        if (Req_Done != '0) begin
            if (!cur_valid) begin
                check("unexpected_done", 32'(Req_Done), 32'd0);
            end else begin
                check("done_onehot", 32'(Req_Done), 32'(1 << cur.id));
                check("done_err", 32'(Req_Err), 32'(cur.err));
                check("done_tx_data_held", 32'(Tx_Data), 32'(cur.data));
                cur_valid = 1'b0;
            end
        end else if (Req_Err) begin
            check("err_without_done", 32'(Req_Err), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fair_bytes [4];
        int         n;
        bit         quiet;

        fair_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        Rst       = 1'b1;
        Req       = '0;
        Req_Data  = '0;
        BIST_Busy = 1'b0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_start", 32'(Transmit_Start), 32'd0);
        check("rst_arb_busy", 32'(Arb_Busy), 32'd0);
        check("rst_ack", 32'(Req_Ack), 32'd0);
        check("rst_done", 32'(Req_Done), 32'd0);
        check("rst_err", 32'(Req_Err), 32'd0);
        check("rst_tx_data", 32'(Tx_Data), 32'd0);
        check("rst_grant_id", 32'(Grant_Id), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_no_ack", 32'(Req_Ack), 32'd0);

        // Fairness: all four requesting, eight frames, order 0,1,2,3,0,1,2,3
        Req_Data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int f = 0; f < 8; f++) exp_q.push_back('{id: f % 4, data: fair_bytes[f % 4], err: 1'b0});
        Req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            wait_ack("fair");
            Req = Req & ~Req_Ack;
            @(negedge Clk);
            Req = 4'b1111;
            wait_done("fair");
        end
        Req = '0;

        // Pointer wrap: last grant was 3, so 0 wins, then 3
        exp_q.push_back('{id: 0, data: 8'h11, err: 1'b0});
        exp_q.push_back('{id: 3, data: 8'h44, err: 1'b0});
        Req = 4'b1001;
        wait_ack("wrap0");
        Req = Req & ~Req_Ack;
        wait_done("wrap0");
        wait_ack("wrap3");
        Req = Req & ~Req_Ack;
        wait_done("wrap3");
        Req = '0;

        // Single request with exact handshake timing
        @(negedge Clk);
        Req_Data = {8'h44, 8'h33, 8'hA5, 8'h11};
        exp_q.push_back('{id: 1, data: 8'hA5, err: 1'b0});
        Req = 4'b0010;
        @(negedge Clk);
        check("single_ack_latency", 32'(Req_Ack), 32'b0010);
        Req = '0;
        check("single_start_c0", 32'(Transmit_Start), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            check($sformatf("single_start_c%0d", k), 32'(Transmit_Start), (k <= 2) ? 32'd1 : 32'd0);
            check($sformatf("single_tx_data_c%0d", k), 32'(Tx_Data), 32'hA5);
            check($sformatf("single_done_c%0d", k), 32'(Req_Done), (k == 7) ? 32'b0010 : 32'd0);
        end

        // Start-handshake timeout: UART never goes busy
        uart_mode = 1;
        Req_Data  = {8'h44, 8'h5C, 8'h22, 8'h11};
        exp_q.push_back('{id: 2, data: 8'h5C, err: 1'b1});
        @(negedge Clk);
        Req = 4'b0100;
        @(negedge Clk);
        check("timeout_ack", 32'(Req_Ack), 32'b0100);
        Req = '0;
        n = 0;
        while (Transmit_Start && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check("timeout_start_len", 32'(n), 32'(START_TIMEOUT));
        check("timeout_done", 32'(Req_Done), 32'b0100);
        check("timeout_err", 32'(Req_Err), 32'd1);
        check("timeout_idle", 32'(Arb_Busy), 32'd0);
        uart_mode = 0;

        // BIST hold: no grant while BIST_Busy, Ack one cycle after it falls
        Req_Data  = {8'h44, 8'h33, 8'h22, 8'h11};
        BIST_Busy = 1'b1;
        exp_q.push_back('{id: 0, data: 8'h11, err: 1'b0});
        Req   = 4'b0001;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (Req_Ack != '0) quiet = 1'b0;
        end
        check("bist_hold_no_ack", 32'(quiet), 32'd1);
        BIST_Busy = 1'b0;
        @(negedge Clk);
        check("bist_release_ack", 32'(Req_Ack), 32'b0001);
        Req = '0;
        wait_done("bist");

        // Reset while in SEND: no Done, pointer back to requester 0
        exp_q.push_back('{id: 2, data: 8'h33, err: 1'b0});
        Req = 4'b0100;
        wait_ack("rstsend");
        Req = '0;
        n = 0;
        while (Transmit_Start && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("rstsend_in_send", 32'(Arb_Busy && !Transmit_Start), 32'd1);
        Rst       = 1'b1;
        cur_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        check("rstsend_start", 32'(Transmit_Start), 32'd0);
        check("rstsend_arb_busy", 32'(Arb_Busy), 32'd0);
        check("rstsend_tx_data", 32'(Tx_Data), 32'd0);
        check("rstsend_grant_id", 32'(Grant_Id), 32'd0);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (Req_Done != '0) quiet = 1'b0;
        end
        check("rstsend_no_done", 32'(quiet), 32'd1);
        exp_q.push_back('{id: 0, data: 8'h11, err: 1'b0});
        exp_q.push_back('{id: 2, data: 8'h33, err: 1'b0});
        Req = 4'b0101;
        wait_ack("post_rst0");
        Req = Req & ~Req_Ack;
        wait_done("post_rst0");
        wait_ack("post_rst2");
        Req = Req & ~Req_Ack;
        wait_done("post_rst2");
        Req = '0;

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("no_open_grant", 32'(cur_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (Tx_Data / Transmit_Start / Tx_Busy handshake) among NUM_REQ on-chip requesters using round-robin arbitration. Each requester presents a byte plus a request and gets an accept pulse when its data is latched and a done pulse when the frame has left the transmitter. Sits between the client logic and the UART top level, on the baud-rate clock Clk. Holds off all grants while the UART BIST is running.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, data width per frame (1..8; must match the UART)
START_TIMEOUT, 16, Clk cycles allowed between Transmit_Start assertion and Tx_Busy rising
localparam ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1

Ports:
Clk  input  1  baud-rate clock; all logic on posedge
Rst  input  1  synchronous reset, active-high
Req  input  NUM_REQ  per-requester request level; held until the Req_Ack pulse
Req_Data  input  NUM_REQ*DATA_BITS  requester i data on bits [i*DATA_BITS +: DATA_BITS]
Req_Ack  output  NUM_REQ  one-hot 1-cycle pulse: data of requester i latched
Req_Done  output  NUM_REQ  one-hot 1-cycle pulse: frame of requester i finished (or aborted)
Req_Err  output  1  1-cycle pulse coincident with Req_Done when the start handshake timed out
Grant_Id  output  ID_W  index of the current or last granted requester
Tx_Data  output  DATA_BITS  data to the UART transmitter
Transmit_Start  output  1  start strobe to the UART transmitter
Tx_Busy  input  1  UART transmitter busy
BIST_Busy  input  1  UART self-test active; arbitration is frozen while high
Arb_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (Rst=1 at a posedge): state=IDLE. Req_Ack, Req_Done, Req_Err, Transmit_Start, Arb_Busy, Tx_Data, Grant_Id and the round-robin pointer all go to 0. Timeout counter = 0. A reset mid-frame drops Transmit_Start on that edge. No Done pulse is issued for the aborted grant.
- States: IDLE, START, SEND.
- IDLE:
  - Grant condition: |Req && !Tx_Busy && !BIST_Busy.
  - Winner is the first asserted Req at or after the pointer, searching upward modulo NUM_REQ.
  - Next edge: Tx_Data <= winner's data; Grant_Id <= winner; Req_Ack[winner] pulses; state <= START; counter <= 0.
  - Otherwise stay in IDLE with no outputs.
- START:
  - Transmit_Start=1 (registered) and Tx_Data held stable.
  - If Tx_Busy=1: next edge Transmit_Start <= 0, state <= SEND.
  - Else if counter == START_TIMEOUT-1: Transmit_Start <= 0; Req_Done[Grant_Id] and Req_Err pulse; pointer <= Grant_Id+1 (wrap); state <= IDLE.
  - Else counter increments.
- SEND:
  - Wait for Tx_Busy=0.
  - Next edge: Req_Done[Grant_Id] pulses; pointer <= Grant_Id+1, wrapping to 0 at NUM_REQ; state <= IDLE.
- Latency:
  - Req to Req_Ack is 1 cycle when idle.
  - Minimum gap between consecutive grants is 1 IDLE cycle after Done.
- BIST_Busy rising during START or SEND does not abort the transfer. It only blocks the next grant.
- A requester that drops Req before it is granted is simply skipped. Req_Data is sampled only in the grant cycle.
- A single requester asserting continuously is still granted every frame. With several requesters, none waits more than NUM_REQ-1 frames.
- Tx_Data holds its value after Done until the next grant.

Decomposition:
- Package uart_arb_pkg: state enum typedef (IDLE/START/SEND) and the ID_W helper function.
- Sub-module rr_pick: combinational round-robin picker with inputs req and ptr, outputs winner and valid. It is instantiated once.
- FSM, counter and registers stay in uart_tx_arbiter.

Test Plan:
- Single request: Req=4'b0010, Req_Data[15:8]=8'hA5, UART idle.
  - Expect Req_Ack=4'b0010 one cycle later, then Tx_Data=8'hA5 and Transmit_Start=1 until Tx_Busy rises.
  - Expect Req_Done=4'b0010 the cycle after Tx_Busy falls.
- Fairness: Req=4'b1111 held, re-raised after each Ack, across 8 frames.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect Tx_Data sequence to match the per-requester bytes 8'h11/22/33/44.
- Pointer wrap: last grant=3, then Req=4'b1001 → requester 0 granted. After that, requester 3 is granted next.
- Timeout: Tx_Busy tied 0, Req=4'b0100.
  - Expect Transmit_Start high for exactly 16 cycles.
  - Then expect Req_Done=4'b0100 and Req_Err=1 in the same cycle, and a return to IDLE.
- BIST hold: BIST_Busy=1 with Req=4'b0001 → no Ack for 20 cycles. Expect Ack 1 cycle after BIST_Busy falls.
- Reset in SEND: assert Rst for 1 cycle mid-frame.
  - Expect Transmit_Start=0, Arb_Busy=0, no Done pulse.
  - Expect the next grant to start from requester 0.
